// File: rtl/frame_tx_sched.sv
// Two-port frame scheduler: drains FWFT FIFO read ports into one byte stream,
// switching only on frame boundaries. Optional stats: FRAME_TX_SCHED_STATS_EN.
module frame_tx_sched #(
   parameter int IFG_CYC  = 12,
   parameter int FLUSH_TO = 2048,
   parameter int MAX_FRM  = 1518
) (
   input  logic        clk,
   input  logic        arst,
   input  logic [7:0]  p0_do,
   input  logic [7:0]  p1_do,
   input  logic        p0_eod,
   input  logic        p1_eod,
   input  logic        p0_empty,
   input  logic        p1_empty,
   input  logic        p0_aempty,
   input  logic        p1_aempty,
   input  logic        p0_half,
   input  logic        p1_half,
   output logic        p0_re,
   output logic        p1_re,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        tx_last,
   output logic        tx_err,
   input  logic        tx_ready,
   output logic        cur_port,
`ifdef FRAME_TX_SCHED_STATS_EN
   output logic [15:0] p0_frm_cnt,
   output logic [15:0] p1_frm_cnt,
   output logic [7:0]  trunc_cnt,
`endif
   output logic        busy
);

   localparam int BW = $clog2(MAX_FRM) + 1;
   localparam int FW = $clog2(FLUSH_TO) + 1;
   localparam int GW = (IFG_CYC > 0) ? $clog2(IFG_CYC + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER, S_GAP} state_t;

   state_t            state_q, state_d;
   logic [1:0]        empty_v, aempty_v, half_v;
   logic [1:0]        elig, hv, flush_hit;
   logic [1:0][FW-1:0] fcnt_q;
   logic              cur_q, rr_q, gnt_port;
   logic [BW-1:0]     bcnt_q;
   logic [GW-1:0]     gcnt_q;
   logic              grun_q;
   logic [7:0]        data_q;
   logic              vld_q, last_q, err_q;
   logic [7:0]        cur_do;
   logic              cur_eod, cur_empty;
   logic              pop, at_max, last_pop, acc_last, gap_done, grant_evt;

   assign empty_v  = {p1_empty, p0_empty};
   assign aempty_v = {p1_aempty, p0_aempty};
   assign half_v   = {p1_half, p0_half};

   // A nearly-empty port only competes once its flush timer has expired.
   always_comb begin
      flush_hit = '0;
      elig      = '0;
      for (int n = 0; n < 2; n++) begin
         flush_hit[n] = (fcnt_q[n] >= FW'(FLUSH_TO));
         elig[n]      = ~empty_v[n] & (~aempty_v[n] | flush_hit[n]);
      end
   end

   assign hv = half_v & elig;

   always_comb begin
      if (hv == 2'b01)
         gnt_port = 1'b0;
      else if (hv == 2'b10)
         gnt_port = 1'b1;
      else if (elig[~rr_q])
         gnt_port = ~rr_q;
      else
         gnt_port = rr_q;
   end

   assign cur_do    = cur_q ? p1_do    : p0_do;
   assign cur_eod   = cur_q ? p1_eod   : p0_eod;
   assign cur_empty = cur_q ? p1_empty : p0_empty;

   assign pop       = (state_q == S_XFER) & ~cur_empty & (~vld_q | tx_ready);
   assign at_max    = (bcnt_q == BW'(MAX_FRM - 1));
   assign last_pop  = pop & (cur_eod | at_max);
   assign acc_last  = vld_q & tx_ready & last_q;
   assign grant_evt = (state_q == S_ARB) & (|elig);

   always_comb begin
      if (IFG_CYC == 0)
         gap_done = (state_q == S_GAP) & acc_last;
      else
         gap_done = (state_q == S_GAP) & grun_q & (gcnt_q == GW'(IFG_CYC - 1));
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Every grant passes through ARB, giving a fixed two-cycle elig-to-pop latency.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (|elig) state_d = S_ARB;
         S_ARB:  state_d = (|elig) ? S_XFER : S_IDLE;
         S_XFER: if (last_pop) state_d = S_GAP;
         S_GAP:  if (gap_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      p0_re    = pop & ~cur_q;
      p1_re    = pop & cur_q;
      busy     = (state_q != S_IDLE);
      cur_port = cur_q;
      tx_data  = data_q;
      tx_valid = vld_q;
      tx_last  = last_q;
      tx_err   = err_q;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         cur_q  <= 1'b0;
         rr_q   <= 1'b0;
         bcnt_q <= '0;
         data_q <= '0;
         vld_q  <= 1'b0;
         last_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (grant_evt) begin
            cur_q  <= gnt_port;
            bcnt_q <= '0;
         end
         if (pop) begin
            data_q <= cur_do;
            vld_q  <= 1'b1;
            last_q <= cur_eod | at_max;
            err_q  <= ~cur_eod & at_max;
            bcnt_q <= bcnt_q + BW'(1);
         end else if (vld_q & tx_ready) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
         end
         if (last_pop)
            rr_q <= cur_q;
      end
   end

   // Gap timing starts only once the closing byte has left the output register.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         grun_q <= 1'b0;
         gcnt_q <= '0;
      end else if ((state_q == S_GAP) && !grun_q && acc_last && (IFG_CYC > 0)) begin
         grun_q <= 1'b1;
         gcnt_q <= '0;
      end else if (grun_q) begin
         if (gap_done)
            grun_q <= 1'b0;
         gcnt_q <= gcnt_q + GW'(1);
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         fcnt_q <= '0;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (empty_v[n] | ~aempty_v[n] | (grant_evt & (gnt_port == 1'(n))))
               fcnt_q[n] <= '0;
            else if (!((state_q == S_XFER) && (cur_q == 1'(n))) && !flush_hit[n])
               fcnt_q[n] <= fcnt_q[n] + FW'(1);
         end
      end
   end

`ifdef FRAME_TX_SCHED_STATS_EN
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         p0_frm_cnt <= '0;
         p1_frm_cnt <= '0;
         trunc_cnt  <= '0;
      end else if (acc_last) begin
         if (cur_q)
            p1_frm_cnt <= p1_frm_cnt + 16'd1;
         else
            p0_frm_cnt <= p0_frm_cnt + 16'd1;
         if (err_q && (trunc_cnt != 8'hFF))
            trunc_cnt <= trunc_cnt + 8'd1;
      end
   end
`endif

endmodule
